// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/writeback with memory wait timeout.
// Optional illegal-opcode trap state is enabled by defining ILLEGAL_OP_TRAP_EN.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op_code,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] mem_to_reg,
   output logic [1:0] reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       mem_timeout,
   output logic       illegal_op
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXEC     = 4'd6;
   localparam logic [3:0] S_ALU_WB   = 4'd7;
   localparam logic [3:0] S_IMM_EXEC = 4'd8;
   localparam logic [3:0] S_IMM_WB   = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JAL      = 4'd11;
   localparam logic [3:0] S_JR       = 4'd12;
   localparam logic [3:0] S_TRAP     = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             imm_and_q, imm_and_d;
   logic             wait_st;
   logic             timeout;

   assign state   = state_q;
   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   // Completion wins over expiry: a timeout needs mem_ready low on the last allowed cycle.
   assign timeout = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == TO_LAST);
   assign mem_timeout = timeout;

`ifdef ILLEGAL_OP_TRAP_EN
   assign illegal_op = (state_q == S_TRAP);
`else
   assign illegal_op = 1'b0;
`endif

   // Counter is zero outside the wait states, so entry into a wait state starts it at zero.
   always_comb begin
      cnt_d = '0;
      if (wait_st && !mem_ready && !timeout) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      imm_and_d     = imm_and_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 2'b00;
      reg_dst       = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
            else if (timeout) state_d = S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            imm_and_d = (op_code == OP_ANDI);
            case (op_code)
               OP_LW, OP_SW:     state_d = S_MEM_ADDR;
               OP_RTYPE:         state_d = (funct == FN_JR) ? S_JR : S_EXEC;
               OP_ADDI, OP_ANDI: state_d = S_IMM_EXEC;
               OP_BEQ:           state_d = S_BRANCH;
               OP_JAL:           state_d = S_JAL;
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  state_d = S_TRAP;
`else
                  state_d    = S_FETCH;
                  instr_done = 1'b1;
`endif
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
            else if (timeout) state_d = S_FETCH;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
            if (mem_ready || timeout) state_d = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b01;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = imm_and_q ? 2'b11 : 2'b00;
            state_d   = S_IMM_WB;
         end
         S_IMM_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JR: begin
            pc_write   = 1'b1;
            pc_source  = 2'b11;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         imm_and_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         imm_and_q <= imm_and_d;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl: per-cycle state and full control-word checks.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       mem_timeout;
      logic       illegal_op;
   } ctl_t;

   typedef struct {
      logic       rdy;
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] st;
      ctl_t       ctl;
   } vec_t;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, BEQ = 6'b000100, JAL = 6'b000011;

   logic       clk = 1'b0;
   logic       rst, mem_ready;
   logic [5:0] op_code, funct;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic [1:0] mem_to_reg, reg_dst, alu_src_b, alu_op, pc_source;
   logic       reg_write, alu_src_a, instr_done, mem_timeout, illegal_op;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .instr_done(instr_done),
      .mem_timeout(mem_timeout), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic ctl_t c_fetch(input logic rdy, input logic to);
      ctl_t c = '0;
      c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; c.mem_timeout = to;
      return c;
   endfunction
   function automatic ctl_t c_decode(input logic done);
      ctl_t c = '0;
      c.alu_src_b = 2'b11; c.instr_done = done;
      return c;
   endfunction
   function automatic ctl_t c_memaddr();
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      return c;
   endfunction
   function automatic ctl_t c_memrd(input logic to);
      ctl_t c = '0;
      c.mem_read = 1'b1; c.i_or_d = 1'b1; c.mem_timeout = to;
      return c;
   endfunction
   function automatic ctl_t c_memwb();
      ctl_t c = '0;
      c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_memwr(input logic rdy, input logic to);
      ctl_t c = '0;
      c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = rdy; c.mem_timeout = to;
      return c;
   endfunction
   function automatic ctl_t c_exec();
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_op = 2'b10;
      return c;
   endfunction
   function automatic ctl_t c_aluwb();
      ctl_t c = '0;
      c.reg_write = 1'b1; c.reg_dst = 2'b01; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_imm(input logic is_and);
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = is_and ? 2'b11 : 2'b00;
      return c;
   endfunction
   function automatic ctl_t c_immwb();
      ctl_t c = '0;
      c.reg_write = 1'b1; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_branch();
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_jal();
      ctl_t c = '0;
      c.pc_write = 1'b1; c.pc_source = 2'b10; c.reg_write = 1'b1; c.reg_dst = 2'b10;
      c.mem_to_reg = 2'b10; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_jr();
      ctl_t c = '0;
      c.pc_write = 1'b1; c.pc_source = 2'b11; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_trap();
      ctl_t c = '0;
      c.illegal_op = 1'b1;
      return c;
   endfunction

   function automatic ctl_t actual_ctl();
      ctl_t c;
      c.pc_write = pc_write; c.pc_write_cond = pc_write_cond; c.i_or_d = i_or_d;
      c.mem_read = mem_read; c.mem_write = mem_write; c.ir_write = ir_write;
      c.mem_to_reg = mem_to_reg; c.reg_dst = reg_dst; c.reg_write = reg_write;
      c.alu_src_a = alu_src_a; c.alu_src_b = alu_src_b; c.alu_op = alu_op;
      c.pc_source = pc_source; c.instr_done = instr_done; c.mem_timeout = mem_timeout;
      c.illegal_op = illegal_op;
      return c;
   endfunction

   task automatic add(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                      input logic [3:0] st, input ctl_t c);
      vec_t v;
      v.rdy = rdy; v.op = op; v.fn = fn; v.st = st; v.ctl = c;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] st, input ctl_t c);
      ctl_t a;
      a = actual_ctl();
      checks++;
      if (state !== st) begin
         errors++;
         $display("FAIL %s state: got %0d want %0d", name, state, st);
      end
      checks++;
      if (a !== c) begin
         errors++;
         $display("FAIL %s ctl: got %06h want %06h (state %0d)", name, a, c, state);
      end
   endtask

   // Drive inputs just after the falling edge, check mid-low-phase, then advance one cycle.
   task automatic cyc(input string name, input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                      input logic [3:0] st, input ctl_t c);
      mem_ready = rdy; op_code = op; funct = fn;
      #1;
      check(name, st, c);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; op_code = '0; funct = '0;

      // add
      add(1, RT, 6'b100000, 0, c_fetch(1, 0));
      add(1, RT, 6'b100000, 1, c_decode(0));
      add(1, RT, 6'b100000, 6, c_exec());
      add(1, RT, 6'b100000, 7, c_aluwb());
      // lw with three wait cycles
      add(1, LW, 0, 0, c_fetch(1, 0));
      add(1, LW, 0, 1, c_decode(0));
      add(1, LW, 0, 2, c_memaddr());
      add(0, LW, 0, 3, c_memrd(0));
      add(0, LW, 0, 3, c_memrd(0));
      add(0, LW, 0, 3, c_memrd(0));
      add(1, LW, 0, 3, c_memrd(0));
      add(1, LW, 0, 4, c_memwb());
      // beq, jal, jr
      add(1, BEQ, 0, 0, c_fetch(1, 0));
      add(1, BEQ, 0, 1, c_decode(0));
      add(1, BEQ, 0, 10, c_branch());
      add(1, JAL, 0, 0, c_fetch(1, 0));
      add(1, JAL, 0, 1, c_decode(0));
      add(1, JAL, 0, 11, c_jal());
      add(1, RT, 6'b001000, 0, c_fetch(1, 0));
      add(1, RT, 6'b001000, 1, c_decode(0));
      add(1, RT, 6'b001000, 12, c_jr());
      // addi, andi (opcode changed after decode must not affect alu_op)
      add(1, ADDI, 0, 0, c_fetch(1, 0));
      add(1, ADDI, 0, 1, c_decode(0));
      add(1, ADDI, 0, 8, c_imm(0));
      add(1, ADDI, 0, 9, c_immwb());
      add(1, ANDI, 0, 0, c_fetch(1, 0));
      add(1, ANDI, 0, 1, c_decode(0));
      add(1, RT, 0, 8, c_imm(1));
      add(1, RT, 0, 9, c_immwb());
      // sw with one fetch wait
      add(0, SW, 0, 0, c_fetch(0, 0));
      add(1, SW, 0, 0, c_fetch(1, 0));
      add(1, SW, 0, 1, c_decode(0));
      add(1, SW, 0, 2, c_memaddr());
      add(1, SW, 0, 5, c_memwr(1, 0));

      @(posedge clk); @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc("reset", 0, RT, 0, 0, c_fetch(0, 0));

      foreach (vecs[i]) cyc($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].op, vecs[i].fn, vecs[i].st, vecs[i].ctl);

      // sw timeout: 16 cycles in MEM_WR, pulse on the 16th
      cyc("sw_to_fetch", 1, SW, 0, 0, c_fetch(1, 0));
      cyc("sw_to_dec", 1, SW, 0, 1, c_decode(0));
      cyc("sw_to_addr", 1, SW, 0, 2, c_memaddr());
      for (int k = 1; k <= 16; k++)
         cyc($sformatf("sw_to_wait%0d", k), 0, SW, 0, 5, c_memwr(0, k == 16));

      // lw: reset mid-wait, then fetch timeout counted from a cleared counter
      cyc("rst_fetch", 1, LW, 0, 0, c_fetch(1, 0));
      cyc("rst_dec", 1, LW, 0, 1, c_decode(0));
      cyc("rst_addr", 1, LW, 0, 2, c_memaddr());
      cyc("rst_wait1", 0, LW, 0, 3, c_memrd(0));
      cyc("rst_wait2", 0, LW, 0, 3, c_memrd(0));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++)
         cyc($sformatf("fetch_to%0d", k), 0, LW, 0, 0, c_fetch(0, k == 16));

      // lw: mem_ready on the timeout cycle completes the access
      cyc("win_fetch", 1, LW, 0, 0, c_fetch(1, 0));
      cyc("win_dec", 1, LW, 0, 1, c_decode(0));
      cyc("win_addr", 1, LW, 0, 2, c_memaddr());
      for (int k = 1; k <= 15; k++)
         cyc($sformatf("win_wait%0d", k), 0, LW, 0, 3, c_memrd(0));
      cyc("win_last", 1, LW, 0, 3, c_memrd(0));
      cyc("win_wb", 1, LW, 0, 4, c_memwb());

      // illegal opcode
      cyc("ill_fetch", 1, 6'b111111, 0, 0, c_fetch(1, 0));
`ifdef ILLEGAL_OP_TRAP_EN
      cyc("ill_dec", 1, 6'b111111, 0, 1, c_decode(0));
      for (int k = 1; k <= 20; k++)
         cyc($sformatf("trap%0d", k), k[0], 6'b111111, 0, 13, c_trap());
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc("trap_rst", 0, RT, 0, 0, c_fetch(0, 0));
`else
      cyc("ill_dec", 1, 6'b111111, 0, 1, c_decode(1));
      cyc("ill_nop", 0, RT, 0, 0, c_fetch(0, 0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
